ethernet_tx_encapsulator: RTL and testbench
===========================================

Name: ethernet_tx_encapsulator

Overview:
Transmit-side counterpart of ethernet_rx_parser. It accepts a UDP payload AXI-Stream plus a per-packet length sideband and prepends a 42-byte Ethernet II + IPv4 + UDP header. The IPv4 header checksum is computed internally. Because the header is 42 bytes, the payload is re-aligned with a 2-byte shift. The output is a framed 64-bit AXI-Stream toward the MAC.

Parameters:
DATA_WIDTH, 64, stream width; only 64 is supported.
IP_TTL, 8'h40, TTL field value.
IP_ID_INIT, 16'h0000, reset value of the IPv4 identification counter.

Ports:
clk  in  1  clock
rstn  in  1  reset; synchronous, active-low
cfg_dst_mac  in  48  destination MAC
cfg_src_mac  in  48  source MAC
cfg_src_ip  in  32  source IPv4 address
cfg_dst_ip  in  32  destination IPv4 address
cfg_src_port  in  16  UDP source port
cfg_dst_port  in  16  UDP destination port
s_meta_valid  in  1  payload length valid
s_meta_ready  out  1  length accepted
s_meta_len  in  16  payload length in bytes
s_axis_tdata  in  64  payload data
s_axis_tkeep  in  8  byte enables
s_axis_tvalid  in  1  payload valid
s_axis_tready  out  1  payload ready
s_axis_tlast  in  1  last payload beat
m_axis_tdata  out  64  framed output data
m_axis_tkeep  out  8  output byte enables
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last output beat

Behaviour:
- Byte order: byte 0 of each beat is tdata[63:56], enabled by tkeep[7].
- tkeep is contiguous from the MSB. Input tkeep may be partial only on the tlast beat; otherwise 0xFF.
- Reset (rstn=0 at posedge):
  - m_axis_tvalid, tlast, tdata, tkeep = 0; s_axis_tready = 0.
  - State = IDLE; ID counter = IP_ID_INIT.
  - A frame in progress is abandoned with no tlast emitted.
- s_meta_ready = 1 only in IDLE.
- Meta handshake: latches len and all cfg_* inputs, then goes to CSUM. cfg changes mid-frame have no effect.
- CSUM (1 cycle):
  - total_len = len+28; udp_len = len+8 (16-bit, wraps).
  - Checksum = ~fold(fold(sum of the 10 header 16-bit words with checksum field = 0)).
  - Next state: HDR.
- Header bytes:
  - 0-5 dst MAC; 6-11 src MAC; 12-13 0x0800; 14 0x45; 15 0x00.
  - 16-17 total_len; 18-19 ID; 20-21 0x4000; 22 IP_TTL; 23 0x11; 24-25 checksum.
  - 26-29 src IP; 30-33 dst IP; 34-35 src port; 36-37 dst port; 38-39 udp_len; 40-41 0x0000 (UDP checksum unused).
- HDR: emits header bytes 0-39 as 5 beats, keep 0xFF, tlast=0, then goes to MERGE.
- MERGE:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - Each accepted beat outputs {2 carry bytes, input bytes 0-5}. The carry is header bytes 40-41 for the first payload beat, then the previous input bytes 6-7.
  - On the last input beat with n valid bytes:
    - n<=6: output keep = top (n+2) bits, tlast=1, next IDLE.
    - n>=7: output keep 0xFF, tlast=0, next TAIL.
- TAIL: emits the residual n-6 bytes (keep 0x80 or 0xC0), tlast=1, next IDLE.
- len==0: the header-only frame ends on beat 5 with keep 0xC0, tlast=1. No payload is consumed.
- The ID counter increments (wrapping 0xFFFF->0x0000) when each frame's final beat is accepted.
- Output handshake:
  - Output is registered; m_axis_tvalid, tdata, tkeep and tlast are held stable while tvalid && !tready.
  - Sustained throughput is 1 beat per cycle under tready=1.
  - Simultaneous tlast-accept and meta_valid: the meta is taken in the next cycle (IDLE), giving a 2-cycle gap before the next header.
- Latency: meta accept -> first header beat valid = 2 cycles.
- len vs. actual payload bytes is not checked; framing follows s_axis_tlast.

Test Plan:
- IP 192.168.0.1->192.168.0.2, ports 0x1388->0x2710, len=8, one payload beat 0xAABBCCDDEEFF0011 keep 0xFF, tready=1:
  - Response: 7 output beats.
  - Beat 2 bytes 16-19 = 0x0024_0000; beat 3 checksum bytes = 0xB975; beat 4 bytes 38-39 = 0x0010.
  - Beat 5 = 0x0000AABBCCDDEEFF; beat 6 = 0x0011 in the top bytes, keep 0xC0, tlast=1.
- len=4, payload keep 0xF0 -> 6 beats; beat 5 = 0x0000_payload[63:32]_0000, keep 0xFC, tlast=1.
- len=32 (4 full beats), m_axis_tready toggled 1010...:
  - Output data matches the no-stall run.
  - tvalid/tdata stay stable when stalled.
  - Last beat keep 0xC0.
- Back-to-back frames with meta_valid held high:
  - IDs 0x0000 then 0x0001; each checksum recomputed.
  - Setting IP_ID_INIT=0xFFFF wraps the ID to 0x0000.
- len=0 -> 6 beats; beat 5 keep 0xC0, tlast=1; s_axis_tready never asserted.
- rstn=0 during MERGE:
  - Next cycle: m_axis_tvalid=0, s_meta_ready=1, ID back to init.
  - The following frame is correct.

Source files
------------

// File: rtl/ethernet_tx_encapsulator.sv
// Ethernet II + IPv4 + UDP transmit encapsulator.
// Prepends a 42-byte header and realigns the payload by two bytes.
module ethernet_tx_encapsulator #(
   parameter int          DATA_WIDTH = 64,
   parameter logic [7:0]  IP_TTL     = 8'h40,
   parameter logic [15:0] IP_ID_INIT = 16'h0000
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [47:0]               cfg_dst_mac,
   input  logic [47:0]               cfg_src_mac,
   input  logic [31:0]               cfg_src_ip,
   input  logic [31:0]               cfg_dst_ip,
   input  logic [15:0]               cfg_src_port,
   input  logic [15:0]               cfg_dst_port,
   input  logic                      s_meta_valid,
   output logic                      s_meta_ready,
   input  logic [15:0]               s_meta_len,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tlast,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast
);

   typedef enum logic [2:0] {
      S_IDLE, S_CSUM, S_HDR, S_MERGE, S_TAIL
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [47:0] dmac_q, dmac_d, smac_q, smac_d;
   logic [31:0] sip_q, sip_d, dip_q, dip_d;
   logic [15:0] sport_q, sport_d, dport_q, dport_d;
   logic [15:0] id_q, id_d, csum_q, csum_d;
   logic [2:0]  beat_q, beat_d;
   logic [15:0] carry_q, carry_d;
   logic [1:0]  tailk_q, tailk_d;
   logic [63:0] tdata_q, tdata_d;
   logic [7:0]  tkeep_q, tkeep_d;
   logic        tvalid_q, tvalid_d, tlast_q, tlast_d;

   logic [63:0] din, hdr_beat;
   logic        out_free, meta_hs, in_hs;
   logic [15:0] total_len, udp_len, fold2;
   logic [19:0] sum;
   logic [16:0] fold1;

   // bytes without their keep bit are forced to zero
   always_comb begin
      din = '0;
      for (int b = 0; b < 8; b++)
         din[8*b +: 8] = s_axis_tdata[8*b +: 8] & {8{s_axis_tkeep[b]}};
   end

   assign out_free      = !tvalid_q || m_axis_tready;
   assign s_meta_ready  = (state_q == S_IDLE) && !tvalid_q;
   assign s_axis_tready = (state_q == S_MERGE) && out_free;
   assign meta_hs       = s_meta_valid && s_meta_ready;
   assign in_hs         = s_axis_tvalid && s_axis_tready;
   assign total_len     = len_q + 16'd28;
   assign udp_len       = len_q + 16'd8;

   assign sum = 20'h4500 + 20'(total_len) + 20'(id_q)
              + 20'h4000 + 20'({IP_TTL, 8'h11})
              + 20'(sip_q[31:16]) + 20'(sip_q[15:0])
              + 20'(dip_q[31:16]) + 20'(dip_q[15:0]);
   assign fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
   assign fold2 = fold1[15:0] + 16'(fold1[16]);

   always_comb begin
      case (beat_q)
         3'd0:    hdr_beat = {dmac_q, smac_q[47:32]};
         3'd1:    hdr_beat = {smac_q[31:0], 16'h0800, 16'h4500};
         3'd2:    hdr_beat = {total_len, id_q, 16'h4000, IP_TTL, 8'h11};
         3'd3:    hdr_beat = {csum_q, sip_q, dip_q[31:16]};
         3'd4:    hdr_beat = {dip_q[15:0], sport_q, dport_q, udp_len};
         default: hdr_beat = 64'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (meta_hs) state_d = S_CSUM;
         S_CSUM:  state_d = S_HDR;
         S_HDR: begin
            if (out_free) begin
               if (beat_q == 3'd5)
                  state_d = S_IDLE;
               else if (beat_q == 3'd4 && len_q != 16'd0)
                  state_d = S_MERGE;
            end
         end
         S_MERGE: begin
            if (in_hs && s_axis_tlast)
               state_d = s_axis_tkeep[1] ? S_TAIL : S_IDLE;
         end
         S_TAIL:  if (out_free) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      len_d    = len_q;
      dmac_d   = dmac_q;
      smac_d   = smac_q;
      sip_d    = sip_q;
      dip_d    = dip_q;
      sport_d  = sport_q;
      dport_d  = dport_q;
      id_d     = id_q;
      csum_d   = csum_q;
      beat_d   = beat_q;
      carry_d  = carry_q;
      tailk_d  = tailk_q;
      tdata_d  = tdata_q;
      tkeep_d  = tkeep_q;
      tlast_d  = tlast_q;
      tvalid_d = out_free ? 1'b0 : tvalid_q;
      if (tvalid_q && m_axis_tready && tlast_q)
         id_d = id_q + 16'd1;
      unique case (state_q)
         S_IDLE: begin
            if (meta_hs) begin
               len_d   = s_meta_len;
               dmac_d  = cfg_dst_mac;
               smac_d  = cfg_src_mac;
               sip_d   = cfg_src_ip;
               dip_d   = cfg_dst_ip;
               sport_d = cfg_src_port;
               dport_d = cfg_dst_port;
               beat_d  = 3'd0;
               carry_d = 16'h0000;
            end
         end
         S_CSUM: csum_d = ~fold2;
         S_HDR: begin
            if (out_free) begin
               tvalid_d = 1'b1;
               tdata_d  = hdr_beat;
               tkeep_d  = (beat_q == 3'd5) ? 8'hC0 : 8'hFF;
               tlast_d  = (beat_q == 3'd5);
               beat_d   = beat_q + 3'd1;
            end
         end
         S_MERGE: begin
            if (in_hs) begin
               tvalid_d = 1'b1;
               tdata_d  = {carry_q, din[63:16]};
               carry_d  = din[15:0];
               tailk_d  = s_axis_tkeep[1:0];
               tkeep_d  = 8'hFF;
               tlast_d  = 1'b0;
               if (s_axis_tlast && !s_axis_tkeep[1]) begin
                  tkeep_d = {2'b11, s_axis_tkeep[7:2]};
                  tlast_d = 1'b1;
               end
            end
         end
         S_TAIL: begin
            if (out_free) begin
               tvalid_d = 1'b1;
               tdata_d  = {carry_q, 48'h0};
               tkeep_d  = {tailk_q, 6'b0};
               tlast_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         len_q    <= '0;
         dmac_q   <= '0;
         smac_q   <= '0;
         sip_q    <= '0;
         dip_q    <= '0;
         sport_q  <= '0;
         dport_q  <= '0;
         id_q     <= IP_ID_INIT;
         csum_q   <= '0;
         beat_q   <= '0;
         carry_q  <= '0;
         tailk_q  <= '0;
         tdata_q  <= '0;
         tkeep_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         len_q    <= len_d;
         dmac_q   <= dmac_d;
         smac_q   <= smac_d;
         sip_q    <= sip_d;
         dip_q    <= dip_d;
         sport_q  <= sport_d;
         dport_q  <= dport_d;
         id_q     <= id_d;
         csum_q   <= csum_d;
         beat_q   <= beat_d;
         carry_q  <= carry_d;
         tailk_q  <= tailk_d;
         tdata_q  <= tdata_d;
         tkeep_q  <= tkeep_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_ethernet_tx_encapsulator.sv
// Randomised bench for ethernet_tx_encapsulator with a byte-level
// frame model; a second instance starts its ID counter at 0xFFFF.
module tb_ethernet_tx_encapsulator;
   localparam int NF = 64;
   localparam logic [15:0] INIT2 = 16'hFFFF;
   localparam int META_TO_VALID = 3;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic [47:0] cfg_dst_mac, cfg_src_mac;
   logic [31:0] cfg_src_ip, cfg_dst_ip;
   logic [15:0] cfg_src_port, cfg_dst_port, s_meta_len;
   logic        s_meta_valid, s_axis_tvalid, s_axis_tlast, m_ready;
   logic [63:0] s_axis_tdata;
   logic [7:0]  s_axis_tkeep;
   logic        mrdy1, srdy1, mv1, ml1, mrdy2, srdy2, mv2, ml2;
   logic [63:0] md1, md2;
   logic [7:0]  mk1, mk2;

   ethernet_tx_encapsulator u_dut1 (
      .clk(clk), .rstn(rstn),
      .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac),
      .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
      .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
      .s_meta_valid(s_meta_valid), .s_meta_ready(mrdy1),
      .s_meta_len(s_meta_len),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(srdy1),
      .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(md1), .m_axis_tkeep(mk1), .m_axis_tvalid(mv1),
      .m_axis_tready(m_ready), .m_axis_tlast(ml1));

   ethernet_tx_encapsulator #(.IP_ID_INIT(INIT2)) u_dut2 (
      .clk(clk), .rstn(rstn),
      .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac),
      .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
      .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
      .s_meta_valid(s_meta_valid), .s_meta_ready(mrdy2),
      .s_meta_len(s_meta_len),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(srdy2),
      .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(md2), .m_axis_tkeep(mk2), .m_axis_tvalid(mv2),
      .m_axis_tready(m_ready), .m_axis_tlast(ml2));

   int tests = 0;
   int fails = 0;
   int mode = 0;
   logic [15:0] f_len [NF];
   logic [47:0] f_dmac [NF], f_smac [NF];
   logic [31:0] f_sip [NF], f_dip [NF];
   logic [15:0] f_sp [NF], f_dp [NF];
   logic [7:0]  pay [NF][64];
   beat_t exp1[$], exp2[$], mq[$];
   logic [15:0] id1, id2;
   logic watch = 1'b0;
   int ntready = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // whole frame as a byte string, then cut into 8-byte beats
   function automatic void model_frame(int f, logic [15:0] id);
      logic [7:0] by [128];
      logic [31:0] s;
      logic [15:0] tl, ul, cs;
      int n;
      tl = f_len[f] + 16'd28;
      ul = f_len[f] + 16'd8;
      for (int j = 0; j < 6; j++) begin
         by[j]   = f_dmac[f][47-8*j -: 8];
         by[6+j] = f_smac[f][47-8*j -: 8];
      end
      by[12] = 8'h08; by[13] = 8'h00; by[14] = 8'h45; by[15] = 8'h00;
      by[16] = tl[15:8]; by[17] = tl[7:0];
      by[18] = id[15:8]; by[19] = id[7:0];
      by[20] = 8'h40; by[21] = 8'h00; by[22] = 8'h40; by[23] = 8'h11;
      by[24] = 8'h00; by[25] = 8'h00;
      for (int j = 0; j < 4; j++) begin
         by[26+j] = f_sip[f][31-8*j -: 8];
         by[30+j] = f_dip[f][31-8*j -: 8];
      end
      by[34] = f_sp[f][15:8]; by[35] = f_sp[f][7:0];
      by[36] = f_dp[f][15:8]; by[37] = f_dp[f][7:0];
      by[38] = ul[15:8]; by[39] = ul[7:0];
      by[40] = 8'h00; by[41] = 8'h00;
      s = 0;
      for (int i = 14; i < 34; i += 2) s += {16'h0, by[i], by[i+1]};
      while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      cs = ~s[15:0];
      by[24] = cs[15:8]; by[25] = cs[7:0];
      n = 42 + int'(f_len[f]);
      for (int j = 0; j < int'(f_len[f]); j++) by[42+j] = pay[f][j];
      mq.delete();
      for (int p = 0; p < n; p += 8) begin
         beat_t b;
         b = '0;
         for (int j = 0; j < 8; j++)
            if (p + j < n) begin
               b.d[63-8*j -: 8] = by[p+j];
               b.k[7-j] = 1'b1;
            end
         b.l = (p + 8 >= n);
         mq.push_back(b);
      end
   endfunction

   task automatic enqueue(input int f);
      model_frame(f, id1);
      foreach (mq[i]) exp1.push_back(mq[i]);
      id1 = id1 + 16'd1;
      model_frame(f, id2);
      foreach (mq[i]) exp2.push_back(mq[i]);
      id2 = id2 + 16'd1;
   endtask

   task automatic rand_frame(input int f, input int len);
      f_len[f]  = 16'(len);
      f_dmac[f] = 48'({$urandom, $urandom});
      f_smac[f] = 48'({$urandom, $urandom});
      f_sip[f]  = $urandom;
      f_dip[f]  = $urandom;
      f_sp[f]   = 16'($urandom);
      f_dp[f]   = 16'($urandom);
      for (int j = 0; j < 64; j++) pay[f][j] = 8'($urandom);
   endtask

   task automatic drive_metas(input int a, input int b);
      bit ok;
      for (int f = a; f <= b; f++) begin
         s_meta_valid = 1'b1;
         s_meta_len   = f_len[f];
         cfg_dst_mac  = f_dmac[f];
         cfg_src_mac  = f_smac[f];
         cfg_src_ip   = f_sip[f];
         cfg_dst_ip   = f_dip[f];
         cfg_src_port = f_sp[f];
         cfg_dst_port = f_dp[f];
         ok = 1'b0;
         for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (mrdy1) begin ok = 1'b1; break; end
         end
         if (!ok) chk("meta_timeout", 64'(f), 64'hFFFF);
         @(posedge clk); #1;
      end
      s_meta_valid = 1'b0;
      cfg_dst_mac  = 48'({$urandom, $urandom});
      cfg_src_ip   = $urandom;
      cfg_src_port = 16'($urandom);
   endtask

   task automatic drive_payload(input int f, input int maxb);
      int n, nb;
      bit ok;
      logic [63:0] d;
      logic [7:0] k;
      n = int'(f_len[f]);
      nb = 0;
      for (int p = 0; p < n && nb < maxb; p += 8) begin
         if (mode == 2) repeat ($urandom_range(0, 2)) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk); #1;
         end
         d = {$urandom, $urandom};
         k = '0;
         for (int j = 0; j < 8; j++)
            if (p + j < n) begin
               d[63-8*j -: 8] = pay[f][p+j];
               k[7-j] = 1'b1;
            end
         s_axis_tdata  = d;
         s_axis_tkeep  = k;
         s_axis_tlast  = (p + 8 >= n);
         s_axis_tvalid = 1'b1;
         ok = 1'b0;
         for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (srdy1) begin ok = 1'b1; break; end
         end
         if (!ok) chk("payload_timeout", 64'(f), 64'hFFFF);
         @(posedge clk); #1;
         nb++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic run_batch(input int a, input int b);
      fork
         drive_metas(a, b);
         for (int f = a; f <= b; f++)
            if (f_len[f] != 0) drive_payload(f, 1000);
      join
   endtask

   task automatic wait_drain();
      int c;
      c = 0;
      while ((exp1.size() != 0 || exp2.size() != 0) && c < 3000) begin
         @(posedge clk); #1;
         c++;
      end
      if (c >= 3000) chk("drain_timeout", 64'(exp1.size()), 64'h0);
      repeat (3) begin @(posedge clk); #1; end
   endtask

   always begin
      @(posedge clk); #1;
      case (mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ~m_ready;
         default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   task automatic check_out(input int which, input beat_t act);
      beat_t e;
      tests++;
      if ((which == 1 && exp1.size() == 0) ||
          (which == 2 && exp2.size() == 0)) begin
         fails++;
         $display("FAIL out%0d unexpected beat got %h", which, act);
         return;
      end
      if (which == 1) e = exp1.pop_front();
      else            e = exp2.pop_front();
      if (act !== e) begin
         fails++;
         $display("FAIL out%0d beat: got d=%h k=%h l=%b expected d=%h k=%h l=%b",
                  which, act.d, act.k, act.l, e.d, e.k, e.l);
      end
   endtask

   bit stall_pend = 1'b0, lat_pend = 1'b0;
   beat_t stall_b;
   int cyc = 0, mcyc = 0;

   always @(negedge clk) begin
      beat_t cur;
      cyc++;
      cur = {md1, mk1, ml1};
      if (!rstn) begin
         stall_pend = 1'b0;
         lat_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            tests++;
            if (!mv1 || cur !== stall_b) begin
               fails++;
               $display("FAIL stall_hold: got v=%b %h expected v=1 %h",
                        mv1, cur, stall_b);
            end
         end
         stall_pend = mv1 && !m_ready;
         stall_b = cur;
         if (lat_pend && mv1) begin
            lat_pend = 1'b0;
            chk("meta_latency", 64'(cyc - mcyc), 64'(META_TO_VALID));
         end
         if (s_meta_valid && mrdy1) begin
            lat_pend = 1'b1;
            mcyc = cyc;
         end
         if (watch && srdy1) ntready++;
         if (mv1 && m_ready) check_out(1, cur);
         if (mv2 && m_ready) check_out(2, {md2, mk2, ml2});
      end
   end

   initial begin
      logic [63:0] pv;
      rstn = 1'b0; m_ready = 1'b1;
      s_meta_valid = 1'b0; s_meta_len = '0;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      s_axis_tdata = '0; s_axis_tkeep = '0;
      cfg_dst_mac = '0; cfg_src_mac = '0; cfg_src_ip = '0;
      cfg_dst_ip = '0; cfg_src_port = '0; cfg_dst_port = '0;
      id1 = 16'h0000; id2 = INIT2;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("rst_tvalid", 64'(mv1), 64'h0);
      chk("rst_tdata", md1, 64'h0);
      chk("rst_tkeep_tlast", {mk1, ml1}, 64'h0);
      chk("rst_s_tready", 64'(srdy1), 64'h0);
      chk("rst_meta_ready", 64'(mrdy1), 64'h1);
      @(posedge clk); #1;

      rand_frame(0, 8);
      f_dmac[0] = 48'h001122334455; f_smac[0] = 48'h665544332211;
      f_sip[0] = 32'hC0A80001; f_dip[0] = 32'hC0A80002;
      f_sp[0] = 16'h1388; f_dp[0] = 16'h2710;
      pv = 64'hAABBCCDDEEFF0011;
      for (int j = 0; j < 8; j++) pay[0][j] = pv[63-8*j -: 8];
      rand_frame(1, 4);
      pv = 64'h12345678_00000000;
      for (int j = 0; j < 4; j++) pay[1][j] = pv[63-8*j -: 8];

      model_frame(0, 16'h0000);
      chk("m0_beats", 64'(mq.size()), 64'd7);
      chk("m0_totlen_id", 64'(mq[2].d[63:32]), 64'h00240000);
      chk("m0_csum", 64'(mq[3].d[63:48]), 64'hB975);
      chk("m0_udplen", 64'(mq[4].d[15:0]), 64'h0010);
      chk("m0_beat5", mq[5].d, 64'h0000AABBCCDDEEFF);
      chk("m0_beat6", {mq[6].d[63:48], mq[6].k, 7'b0, mq[6].l},
          64'h0011_C0_01);
      model_frame(1, 16'h0001);
      chk("m1_beats", 64'(mq.size()), 64'd6);
      chk("m1_beat5", {mq[5].d}, 64'h0000_12345678_0000);
      chk("m1_keep_last", {mq[5].k, 7'b0, mq[5].l}, 64'hFC01);

      mode = 0;
      enqueue(0); enqueue(1);
      run_batch(0, 1);
      wait_drain();

      rand_frame(2, 32);
      model_frame(2, 16'h0000);
      chk("m2_last_keep", {mq[mq.size()-1].k}, 64'hC0);
      mode = 1;
      enqueue(2);
      run_batch(2, 2);
      wait_drain();

      rand_frame(3, 0);
      model_frame(3, 16'h0000);
      chk("m3_beats", 64'(mq.size()), 64'd6);
      chk("m3_keep", 64'(mq[5].k), 64'hC0);
      mode = 0;
      watch = 1'b1;
      enqueue(3);
      run_batch(3, 3);
      wait_drain();
      watch = 1'b0;
      chk("len0_no_tready", 64'(ntready), 64'h0);

      mode = 2;
      for (int f = 4; f < 34; f++) begin
         rand_frame(f, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60));
         enqueue(f);
      end
      run_batch(4, 33);
      wait_drain();

      mode = 0;
      rand_frame(34, 24);
      enqueue(34);
      fork
         drive_metas(34, 34);
         drive_payload(34, 1);
      join
      rstn = 1'b0;
      exp1.delete(); exp2.delete();
      id1 = 16'h0000; id2 = INIT2;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_merge_tvalid", {mv1, mv2}, 64'h0);
      chk("rst_merge_meta_rdy", 64'(mrdy1), 64'h1);
      chk("rst_merge_s_tready", 64'(srdy1), 64'h0);
      @(posedge clk); #1 rstn = 1'b1;
      rand_frame(35, 13);
      enqueue(35);
      run_batch(35, 35);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
